axil_sim_ctrl: RTL

AXI4-Lite responder giving the simulated PicoRV32 firmware a memory-mapped simulation-control peripheral: a console byte FIFO drained over a valid/ready stream, a sticky pass/fail status register, a free-running cycle counter and a scratch register. It sits on the same narrow AXI-Lite bus the `picorv32_axi` core drives (no BRESP/RRESP), beside the test memory. Firmware writes to it, and the harness reads `tests_passed`/`halt` from it.

---
 rtl/axil_sim_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/axil_sim_ctrl.sv
// axil_sim_ctrl: AXI4-Lite simulation-control peripheral for the PicoRV32 test
// harness. Provides a console byte FIFO drained over a valid/ready stream, a
// sticky pass/fail status register, a free-running cycle counter and a scratch
// register in a 32-byte window at ADDR_BASE.
//   clk, resetn          : clock, synchronous active-low reset
//   mem_axi_aw*/w*/b*    : write address / data / response channels (no BRESP)
//   mem_axi_ar*/r*       : read address / data channels (no RRESP)
//   console_*            : FIFO head byte stream, pops on valid & ready
//   tests_passed, halt   : sticky pass flag, sticky pass|fail
module axil_sim_ctrl #(
  parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        console_valid,
  input  logic        console_ready,
  output logic [7:0]  console_data,
  output logic        tests_passed,
  output logic        halt
);
  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [31:0] PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] MISS_DATA  = 32'hDEAD_BEEF;

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0]   aw_addr_q, aw_addr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pass_q, pass_d, fail_q, fail_d;
  logic [31:0]   cycle_q, cycle_d, scratch_q, scratch_d;

  logic          aw_fire, w_fire, ar_fire, wr_hit, rd_hit;
  logic [2:0]    wr_reg, rd_reg;
  logic          fifo_full, con_push_req, exec, push, pop;
  logic [31:0]   count_ext, rd_val;
  logic          unused_bits;

  assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot, aw_addr_q[1:0], mem_axi_araddr[1:0]};

  assign mem_axi_awready = resetn & ~aw_held_q & ~bvalid_q;
  assign mem_axi_wready  = resetn & ~w_held_q & ~bvalid_q;
  assign mem_axi_arready = resetn & ~rvalid_q;
  // Registered outputs are also gated so everything reads 0 while reset is low.
  assign mem_axi_bvalid  = resetn & bvalid_q;
  assign mem_axi_rvalid  = resetn & rvalid_q;
  assign mem_axi_rdata   = resetn ? rdata_q : 32'h0;
  assign console_valid   = resetn & (count_q != '0);
  assign console_data    = resetn ? fifo_q[rd_ptr_q] : 8'h0;
  assign tests_passed    = resetn & pass_q;
  assign halt            = resetn & (pass_q | fail_q);

  always_comb begin
    aw_fire      = mem_axi_awvalid & mem_axi_awready;
    w_fire       = mem_axi_wvalid & mem_axi_wready;
    ar_fire      = mem_axi_arvalid & mem_axi_arready;
    wr_hit       = aw_addr_q[31:5] == ADDR_BASE[31:5];
    wr_reg       = aw_addr_q[4:2];
    rd_hit       = mem_axi_araddr[31:5] == ADDR_BASE[31:5];
    rd_reg       = mem_axi_araddr[4:2];
    // Fullness uses the pre-pop count: a same-cycle pop never admits a push.
    fifo_full    = count_q == CW'(FIFO_DEPTH);
    con_push_req = wr_hit & (wr_reg == 3'd0) & wstrb_q[0];
    exec         = aw_held_q & w_held_q & ~(con_push_req & fifo_full);
    push         = exec & con_push_req;
    pop          = (count_q != '0) & console_ready;
    count_ext    = 32'(count_q);

    aw_held_d = aw_held_q;  aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;   wdata_d   = wdata_q;   wstrb_d = wstrb_q;
    bvalid_d  = bvalid_q;   rvalid_d  = rvalid_q;  rdata_d = rdata_q;
    fifo_d    = fifo_q;     wr_ptr_d  = wr_ptr_q;  rd_ptr_d = rd_ptr_q;
    count_d   = count_q;    pass_d    = pass_q;    fail_d  = fail_q;
    scratch_d = scratch_q;
    cycle_d   = cycle_q + 32'd1;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_addr_d = mem_axi_awaddr;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = mem_axi_wdata;
      wstrb_d  = mem_axi_wstrb;
    end

    // Holds can only fill while bvalid is low, so exec and a pending B never overlap.
    if (exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_hit && wr_reg == 3'd1) begin
        if (wdata_q == PASS_MAGIC) pass_d = 1'b1;
        else                       fail_d = 1'b1;
      end
      if (wr_hit && wr_reg == 3'd3) begin
        for (int b = 0; b < 4; b++)
          if (wstrb_q[b]) scratch_d[b*8 +: 8] = wdata_q[b*8 +: 8];
      end
    end else if (bvalid_q && mem_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = wdata_q[7:0];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Read data comes from pre-write state: a same-cycle write lands at the edge.
    rd_val = MISS_DATA;
    if (rd_hit) begin
      unique case (rd_reg)
        3'd0:    rd_val = {24'h0, count_ext[7:0]};
        3'd1:    rd_val = {30'h0, fail_q, pass_q};
        3'd2:    rd_val = cycle_q;
        3'd3:    rd_val = scratch_q;
        default: rd_val = MISS_DATA;
      endcase
    end
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (rvalid_q && mem_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;  aw_addr_q <= '0;
      w_held_q  <= 1'b0;  wdata_q   <= '0;  wstrb_q <= '0;
      bvalid_q  <= 1'b0;  rvalid_q  <= 1'b0; rdata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;    rd_ptr_q  <= '0;   count_q <= '0;
      pass_q    <= 1'b0;  fail_q    <= 1'b0;
      cycle_q   <= '0;    scratch_q <= '0;
    end else begin
      aw_held_q <= aw_held_d;  aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;   wdata_q   <= wdata_d;   wstrb_q <= wstrb_d;
      bvalid_q  <= bvalid_d;   rvalid_q  <= rvalid_d;  rdata_q <= rdata_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;   rd_ptr_q  <= rd_ptr_d;  count_q <= count_d;
      pass_q    <= pass_d;     fail_q    <= fail_d;
      cycle_q   <= cycle_d;    scratch_q <= scratch_d;
    end
  end
endmodule
